pwm_from_count: RTL and testbench

//  Downstream consumer of the modulo-k cycle counter: turns its count stream into a PWM signal.

---
 rtl/pwm_from_count.sv | 107 ++++++++++
 tb/tb_pwm_from_count.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream modulo-k count stream. Duty updates are
// double-buffered and only take effect at a period boundary (count == 0).
module pwm_from_count #(
  parameter int N = 8,
  parameter int P = 16
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_count,
  input  logic [N-1:0] i_k,
  input  logic [N-1:0] i_duty,
  input  logic         i_duty_valid,
  output logic         o_duty_ready,
  output logic         o_pwm,
  output logic         o_update_done,
  output logic         o_running,
  output logic [P-1:0] o_periods
);

  // Handshake: a duty transfer occurs on a rising edge where i_duty_valid and
  // o_duty_ready are both high; o_duty_ready is !pending, so once a value is
  // captured the requester must hold until it has been applied.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [N-1:0] K_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] PER_ONE = {{(P-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] active_duty_q, active_duty_d;
  logic [N-1:0] pending_duty_q, pending_duty_d;
  logic         pending_q, pending_d;
  logic         pwm_q, pwm_d;
  logic         update_done_q, update_done_d;
  logic [P-1:0] periods_q, periods_d;

  logic         period_start;
  logic         accept;
  logic         apply;
  logic [N-1:0] duty_eff;

  // A modulus of 0 or 1 means the upstream counter never leaves 0.
  assign period_start = (i_count == '0) || (i_k <= K_ONE);
  assign accept       = i_duty_valid && !pending_q;
  assign apply        = period_start && pending_q;
  assign duty_eff     = apply ? pending_duty_q : active_duty_q;

  always_comb begin
    state_d        = state_q;
    active_duty_d  = active_duty_q;
    pending_duty_d = pending_duty_q;
    pending_d      = pending_q;
    pwm_d          = 1'b0;
    update_done_d  = 1'b0;
    periods_d      = periods_q;

    if (accept) begin
      pending_duty_d = i_duty;
      pending_d      = 1'b1;
    end

    if (apply) begin
      active_duty_d = pending_duty_q;
      pending_d     = 1'b0;
      update_done_d = 1'b1;
      state_d       = ST_RUN;
    end

    // The applying cycle already runs the new duty, so it compares and counts.
    if (state_d == ST_RUN) begin
      pwm_d = (i_count < duty_eff);
      if (period_start) begin
        periods_d = periods_q + PER_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      active_duty_q  <= '0;
      pending_duty_q <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      update_done_q  <= 1'b0;
      periods_q      <= '0;
    end else begin
      state_q        <= state_d;
      active_duty_q  <= active_duty_d;
      pending_duty_q <= pending_duty_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      update_done_q  <= update_done_d;
      periods_q      <= periods_d;
    end
  end

  assign o_duty_ready  = !pending_q;
  assign o_pwm         = pwm_q;
  assign o_update_done = update_done_q;
  assign o_running     = (state_q == ST_RUN);
  assign o_periods     = periods_q;

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed bench for pwm_from_count: bench-side modulo-k counter, hand-computed
// expectations, 4-bit period counter so wrap-around is reachable quickly.
module tb_pwm_from_count;

  localparam int N = 8;
  localparam int P = 4;

  logic         clk;
  logic         i_reset_n;
  logic [N-1:0] i_count;
  logic [N-1:0] i_k;
  logic [N-1:0] i_duty;
  logic         i_duty_valid;
  logic         o_duty_ready;
  logic         o_pwm;
  logic         o_update_done;
  logic         o_running;
  logic [P-1:0] o_periods;

  logic [N-1:0] last_count;
  int           n_checks;
  int           n_pass;

  pwm_from_count #(.N(N), .P(P)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_count       (i_count),
    .i_k           (i_k),
    .i_duty        (i_duty),
    .i_duty_valid  (i_duty_valid),
    .o_duty_ready  (o_duty_ready),
    .o_pwm         (o_pwm),
    .o_update_done (o_update_done),
    .o_running     (o_running),
    .o_periods     (o_periods)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // One clock: remember the count presented at the edge, then advance the
  // upstream counter. Outputs observed afterwards reflect last_count.
  task automatic tick();
    last_count = i_count;
    @(posedge clk);
    #1;
    if (i_k <= 8'd1) i_count = '0;
    else i_count = 8'((int'(i_count) + 1) % int'(i_k));
  endtask

  task automatic run_to(input logic [N-1:0] c);
    int guard;
    guard = 0;
    while (i_count != c && guard < 32) begin
      tick();
      guard++;
    end
    n_checks++; if (i_count !== c) $display("FAIL run_to: got count %0d want %0d", i_count, c); else n_pass++;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_k = 8'd10; i_count = '0; i_duty = '0; i_duty_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (o_duty_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_duty_ready); else n_pass++;
    n_checks++; if (o_periods !== 4'd0) $display("FAIL reset_periods: got %0d want 0", o_periods); else n_pass++;
    i_reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++; if (o_pwm !== 1'b0) $display("FAIL idle_pwm: got %b want 0", o_pwm); else n_pass++;
      n_checks++; if (o_running !== 1'b0) $display("FAIL idle_running: got %b want 0", o_running); else n_pass++;
      n_checks++; if (o_periods !== 4'd0) $display("FAIL idle_periods: got %0d want 0", o_periods); else n_pass++;
      n_checks++; if (o_duty_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", o_duty_ready); else n_pass++;
      n_checks++; if (o_update_done !== 1'b0) $display("FAIL idle_upd: got %b want 0", o_update_done); else n_pass++;
    end
  endtask

  task automatic test_first_apply();
    int hi;
    run_to(8'd5);
    i_duty = 8'd3; i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
    n_checks++; if (o_duty_ready !== 1'b0) $display("FAIL fa_ready_drop: got %b want 0", o_duty_ready); else n_pass++;
    n_checks++; if (o_running !== 1'b0) $display("FAIL fa_not_running: got %b want 0", o_running); else n_pass++;
    run_to(8'd0);
    n_checks++; if (o_update_done !== 1'b0) $display("FAIL fa_upd_early: got %b want 0", o_update_done); else n_pass++;
    tick();
    n_checks++; if (o_update_done !== 1'b1) $display("FAIL fa_upd: got %b want 1", o_update_done); else n_pass++;
    n_checks++; if (o_running !== 1'b1) $display("FAIL fa_running: got %b want 1", o_running); else n_pass++;
    n_checks++; if (o_periods !== 4'd1) $display("FAIL fa_periods: got %0d want 1", o_periods); else n_pass++;
    n_checks++; if (o_pwm !== 1'b1) $display("FAIL fa_pwm_first: got %b want 1", o_pwm); else n_pass++;
    n_checks++; if (o_duty_ready !== 1'b1) $display("FAIL fa_ready_back: got %b want 1", o_duty_ready); else n_pass++;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_pwm === 1'b1) hi++;
      n_checks++; if (o_pwm !== (last_count < 8'd3)) $display("FAIL fa_pwm c=%0d: got %b want %b", last_count, o_pwm, (last_count < 8'd3)); else n_pass++;
      n_checks++; if (o_update_done !== 1'b0) $display("FAIL fa_upd_pulse: got %b want 0", o_update_done); else n_pass++;
    end
    n_checks++; if (hi !== 3) $display("FAIL fa_high_count: got %0d want 3", hi); else n_pass++;
    n_checks++; if (o_periods !== 4'd2) $display("FAIL fa_periods2: got %0d want 2", o_periods); else n_pass++;
  endtask

  task automatic test_apply_at_boundary();
    int hi;
    run_to(8'd0);
    i_duty = 8'd7; i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
    n_checks++; if (o_update_done !== 1'b0) $display("FAIL ab_no_apply: got %b want 0", o_update_done); else n_pass++;
    n_checks++; if (o_duty_ready !== 1'b0) $display("FAIL ab_ready: got %b want 0", o_duty_ready); else n_pass++;
    n_checks++; if (o_periods !== 4'd3) $display("FAIL ab_periods3: got %0d want 3", o_periods); else n_pass++;
    hi = (o_pwm === 1'b1) ? 1 : 0;
    n_checks++; if (o_pwm !== 1'b1) $display("FAIL ab_pwm_c0: got %b want 1", o_pwm); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (o_pwm === 1'b1) hi++;
      n_checks++; if (o_pwm !== (last_count < 8'd3)) $display("FAIL ab_old_pwm c=%0d: got %b want %b", last_count, o_pwm, (last_count < 8'd3)); else n_pass++;
    end
    n_checks++; if (hi !== 3) $display("FAIL ab_old_high_count: got %0d want 3", hi); else n_pass++;
    tick();
    n_checks++; if (o_update_done !== 1'b1) $display("FAIL ab_apply: got %b want 1", o_update_done); else n_pass++;
    n_checks++; if (o_periods !== 4'd4) $display("FAIL ab_periods4: got %0d want 4", o_periods); else n_pass++;
    n_checks++; if (o_duty_ready !== 1'b1) $display("FAIL ab_ready_back: got %b want 1", o_duty_ready); else n_pass++;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_pwm === 1'b1) hi++;
      n_checks++; if (o_pwm !== (last_count < 8'd7)) $display("FAIL ab_new_pwm c=%0d: got %b want %b", last_count, o_pwm, (last_count < 8'd7)); else n_pass++;
    end
    n_checks++; if (hi !== 7) $display("FAIL ab_new_high_count: got %0d want 7", hi); else n_pass++;
    n_checks++; if (o_periods !== 4'd5) $display("FAIL ab_periods5: got %0d want 5", o_periods); else n_pass++;
  endtask

  task automatic test_duty_sweep(input logic [N-1:0] d, input int exp_hi, input logic [P-1:0] exp_per);
    int hi;
    run_to(8'd5);
    i_duty = d; i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
    run_to(8'd0);
    tick();
    n_checks++; if (o_update_done !== 1'b1) $display("FAIL sw_apply d=%0d: got %b want 1", d, o_update_done); else n_pass++;
    n_checks++; if (o_pwm !== (8'd0 < d)) $display("FAIL sw_pwm_first d=%0d: got %b want %b", d, o_pwm, (8'd0 < d)); else n_pass++;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_pwm === 1'b1) hi++;
      n_checks++; if (o_pwm !== (last_count < d)) $display("FAIL sw_pwm d=%0d c=%0d: got %b want %b", d, last_count, o_pwm, (last_count < d)); else n_pass++;
    end
    n_checks++; if (hi !== exp_hi) $display("FAIL sw_high_count d=%0d: got %0d want %0d", d, hi, exp_hi); else n_pass++;
    n_checks++; if (o_periods !== exp_per) $display("FAIL sw_periods d=%0d: got %0d want %0d", d, o_periods, exp_per); else n_pass++;
  endtask

  task automatic test_k1_wrap();
    logic [P-1:0] exp_per;
    i_k = 8'd1; i_count = '0;
    i_duty = 8'd1; i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
    n_checks++; if (o_update_done !== 1'b0) $display("FAIL k1_no_apply: got %b want 0", o_update_done); else n_pass++;
    n_checks++; if (o_duty_ready !== 1'b0) $display("FAIL k1_ready: got %b want 0", o_duty_ready); else n_pass++;
    n_checks++; if (o_periods !== 4'd12) $display("FAIL k1_periods12: got %0d want 12", o_periods); else n_pass++;
    tick();
    n_checks++; if (o_update_done !== 1'b1) $display("FAIL k1_apply: got %b want 1", o_update_done); else n_pass++;
    n_checks++; if (o_periods !== 4'd13) $display("FAIL k1_periods13: got %0d want 13", o_periods); else n_pass++;
    n_checks++; if (o_pwm !== 1'b1) $display("FAIL k1_pwm_first: got %b want 1", o_pwm); else n_pass++;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_per = 4'((13 + i) % 16);
      n_checks++; if (o_periods !== exp_per) $display("FAIL k1_wrap i=%0d: got %0d want %0d", i, o_periods, exp_per); else n_pass++;
      n_checks++; if (o_pwm !== 1'b1) $display("FAIL k1_pwm i=%0d: got %b want 1", i, o_pwm); else n_pass++;
      n_checks++; if (o_update_done !== 1'b0) $display("FAIL k1_upd i=%0d: got %b want 0", i, o_update_done); else n_pass++;
    end
  endtask

  task automatic test_reset_pending();
    i_k = 8'd10; i_count = '0;
    i_duty = 8'd9; i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
    n_checks++; if (o_duty_ready !== 1'b0) $display("FAIL rp_ready: got %b want 0", o_duty_ready); else n_pass++;
    n_checks++; if (o_pwm !== 1'b1) $display("FAIL rp_pwm: got %b want 1", o_pwm); else n_pass++;
    n_checks++; if (o_periods !== 4'd15) $display("FAIL rp_periods: got %0d want 15", o_periods); else n_pass++;
    #2;
    i_reset_n = 1'b0;
    #1;
    n_checks++; if (o_pwm !== 1'b0) $display("FAIL rp_async_pwm: got %b want 0", o_pwm); else n_pass++;
    n_checks++; if (o_running !== 1'b0) $display("FAIL rp_async_running: got %b want 0", o_running); else n_pass++;
    n_checks++; if (o_periods !== 4'd0) $display("FAIL rp_async_periods: got %0d want 0", o_periods); else n_pass++;
    n_checks++; if (o_update_done !== 1'b0) $display("FAIL rp_async_upd: got %b want 0", o_update_done); else n_pass++;
    n_checks++; if (o_duty_ready !== 1'b1) $display("FAIL rp_async_ready: got %b want 1", o_duty_ready); else n_pass++;
    repeat (2) tick();
    i_reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++; if (o_update_done !== 1'b0) $display("FAIL rp_discard_upd: got %b want 0", o_update_done); else n_pass++;
      n_checks++; if (o_running !== 1'b0) $display("FAIL rp_discard_running: got %b want 0", o_running); else n_pass++;
      n_checks++; if (o_pwm !== 1'b0) $display("FAIL rp_discard_pwm: got %b want 0", o_pwm); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_count = '0;
    test_reset();
    test_first_apply();
    test_apply_at_boundary();
    test_duty_sweep(8'd0,   0,  4'd7);
    test_duty_sweep(8'd10,  10, 4'd9);
    test_duty_sweep(8'd255, 10, 4'd11);
    test_k1_wrap();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
